// File: rtl/seg_pkg.sv
// Shared constants and types for the four-digit seven-segment scan driver.
package seg_pkg;
    localparam int NUM_DIGITS = 4;
    localparam int SEG_W      = 8;
    localparam int IDX_W      = $clog2(NUM_DIGITS);

    localparam logic [SEG_W-1:0]      SEG_BLANK = 8'hFF;
    localparam logic [NUM_DIGITS-1:0] ANODE_OFF = 4'hF;

    typedef enum logic {
        BLANK,
        SHOW
    } slot_state_e;
endpackage

// File: rtl/seg_refresh_div.sv
// Digit-slot counter: counts 0..REFRESH_DIV-1 while enabled and flags the
// blanking window at the start of each slot plus the slot wrap.
module seg_refresh_div #(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic slot_wrap,
    output logic in_blank
);
    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        slot_wrap = en && (cnt_q == CNT_W'(REFRESH_DIV - 1));
        in_blank  = (cnt_q < CNT_W'(BLANK_CYCLES));
        cnt_d     = cnt_q;
        if (en) begin
            cnt_d = slot_wrap ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/seg_scan_mux.sv
// Time-multiplexed 4-digit seven-segment driver with frame-synchronous double
// buffering and inter-digit blanking. Optional digit blinking: SEG_BLINK_EN.
module seg_scan_mux
    import seg_pkg::*;
#(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000
`ifdef SEG_BLINK_EN
    ,
    parameter int BLINK_FRAMES = 250
`endif
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        en,
    input  logic [NUM_DIGITS*SEG_W-1:0] seg_word,
    input  logic                        load_valid,
    output logic                        load_ready,
    output logic [NUM_DIGITS-1:0]       an,
    output logic [SEG_W-1:0]            cathode,
    output logic                        frame_tick
`ifdef SEG_BLINK_EN
    ,
    input  logic [NUM_DIGITS-1:0]       blink_mask
`endif
);
    logic                        slot_wrap;
    logic                        in_blank;
    logic                        frame_wrap;
    logic                        load_fire;
    slot_state_e                 slot_state;
    logic [SEG_W-1:0]            digit_seg;

    logic [IDX_W-1:0]            idx_q, idx_d;
    logic [NUM_DIGITS*SEG_W-1:0] shadow_q, shadow_d;
    logic [NUM_DIGITS*SEG_W-1:0] pending_q, pending_d;
    logic                        pend_full_q, pend_full_d;
    logic [NUM_DIGITS-1:0]       an_q, an_d;
    logic [SEG_W-1:0]            cathode_q, cathode_d;

    seg_refresh_div #(
        .REFRESH_DIV (REFRESH_DIV),
        .BLANK_CYCLES(BLANK_CYCLES)
    ) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .slot_wrap(slot_wrap),
        .in_blank (in_blank)
    );

`ifdef SEG_BLINK_EN
    localparam int BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [BLK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic             blink_on_q, blink_on_d;

    always_comb begin
        blink_cnt_d = blink_cnt_q;
        blink_on_d  = blink_on_q;
        if (frame_wrap) begin
            if (blink_cnt_q == BLK_W'(BLINK_FRAMES - 1)) begin
                blink_cnt_d = '0;
                blink_on_d  = !blink_on_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt_q <= '0;
            blink_on_q  <= 1'b1;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            blink_on_q  <= blink_on_d;
        end
    end
`endif

    always_comb begin
        frame_wrap = slot_wrap && (idx_q == IDX_W'(NUM_DIGITS - 1));
        load_fire  = load_valid && !pend_full_q;
        slot_state = in_blank ? BLANK : SHOW;

        idx_d = idx_q;
        if (slot_wrap) begin
            idx_d = frame_wrap ? '0 : idx_q + 1'b1;
        end

        // Promotion needs a full pending buffer, capture needs an empty one,
        // so the two never collide in the same cycle.
        shadow_d    = shadow_q;
        pending_d   = pending_q;
        pend_full_d = pend_full_q;
        if (frame_wrap && pend_full_q) begin
            shadow_d    = pending_q;
            pend_full_d = 1'b0;
        end
        if (load_fire) begin
            pending_d   = seg_word;
            pend_full_d = 1'b1;
        end

        digit_seg = shadow_q[SEG_W*idx_q +: SEG_W];
`ifdef SEG_BLINK_EN
        if (!blink_on_q && blink_mask[idx_q]) begin
            digit_seg = SEG_BLANK;
        end
`endif

        an_d      = ANODE_OFF;
        cathode_d = SEG_BLANK;
        if (en && slot_state == SHOW) begin
            an_d      = ~(NUM_DIGITS'(1) << idx_q);
            cathode_d = digit_seg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q       <= '0;
            shadow_q    <= '1;
            pending_q   <= '1;
            pend_full_q <= 1'b0;
            an_q        <= ANODE_OFF;
            cathode_q   <= SEG_BLANK;
        end else begin
            idx_q       <= idx_d;
            shadow_q    <= shadow_d;
            pending_q   <= pending_d;
            pend_full_q <= pend_full_d;
            an_q        <= an_d;
            cathode_q   <= cathode_d;
        end
    end

    assign an         = an_q;
    assign cathode    = cathode_q;
    assign load_ready = !pend_full_q;
    assign frame_tick = frame_wrap;
endmodule

// File: tb/tb_seg_scan_mux.sv
// Randomized self-checking bench for seg_scan_mux against a frame-position
// reference model (position 0..15 within a frame of 4 slots x 4 cycles).
module tb_seg_scan_mux;
    localparam int RD        = 4;
    localparam int BC        = 1;
    localparam int FRAME_LEN = 4 * RD;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [31:0] seg_word = '0;
    logic        load_valid = 1'b0;
    logic        load_ready;
    logic [3:0]  an;
    logic [7:0]  cathode;
    logic        frame_tick;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    int          m_pos;
    logic [31:0] m_shadow;
    logic [31:0] pend[$];
    logic [3:0]  exp_an;
    logic [7:0]  exp_cath;

    always #5 clk = ~clk;

    seg_scan_mux #(
        .REFRESH_DIV (RD),
        .BLANK_CYCLES(BC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .seg_word  (seg_word),
        .load_valid(load_valid),
        .load_ready(load_ready),
        .an        (an),
        .cathode   (cathode),
        .frame_tick(frame_tick)
`ifdef SEG_BLINK_EN
        ,
        .blink_mask(4'b0000)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pos    = 0;
        m_shadow = 32'hFFFF_FFFF;
        pend.delete();
        exp_an   = 4'hF;
        exp_cath = 8'hFF;
    endtask

    // One clock cycle: check registered outputs, drive inputs, check the
    // combinational tick, then advance the model across the coming edge.
    task automatic step(input bit e, input bit v, input logic [31:0] w, output bit acc);
        int         d;
        bit         show;
        logic [3:0] onehot;
        @(negedge clk);
        chk("an", {28'b0, an}, {28'b0, exp_an});
        chk("cathode", {24'b0, cathode}, {24'b0, exp_cath});
        chk("load_ready", {31'b0, load_ready}, {31'b0, pend.size() == 0});
        en         = e;
        load_valid = v;
        seg_word   = w;
        #1;
        chk("frame_tick", {31'b0, frame_tick}, {31'b0, e && (m_pos == FRAME_LEN - 1)});

        d      = m_pos / RD;
        show   = e && ((m_pos % RD) >= BC);
        onehot = 4'b0001 << d;
        exp_an   = show ? ~onehot : 4'hF;
        exp_cath = show ? 8'(m_shadow >> (8 * d)) : 8'hFF;
        acc = v && (pend.size() == 0);
        if (e && m_pos == FRAME_LEN - 1 && pend.size() > 0) m_shadow = pend.pop_front();
        if (acc) pend.push_back(w);
        if (e) m_pos = (m_pos + 1) % FRAME_LEN;
    endtask

    task automatic idle(input int n, input bit e);
        bit acc;
        for (int i = 0; i < n; i++) step(e, 1'b0, 32'h0, acc);
    endtask

    // Present a word and hold it until accepted; expiry counts as a failure.
    task automatic load_word(input logic [31:0] w);
        bit acc;
        int k;
        acc = 1'b0;
        k   = 0;
        while (!acc && k < 4 * FRAME_LEN) begin
            step(1'b1, 1'b1, w, acc);
            k++;
        end
        if (!acc) begin
            n_cmp++;
            n_err++;
            $display("FAIL load_timeout: word %h not accepted within %0d cycles", w, k);
        end
    endtask

    task automatic reset_mid_frame();
        #2;
        rst_n      = 1'b0;
        en         = 1'b0;
        load_valid = 1'b0;
        #1;
        chk("rst_an", {28'b0, an}, 32'hF);
        chk("rst_cathode", {24'b0, cathode}, 32'hFF);
        chk("rst_ready", {31'b0, load_ready}, 32'h1);
        chk("rst_tick", {31'b0, frame_tick}, 32'h0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        bit          acc, hv;
        logic [31:0] hw, w;
        bit          v, e;
        int          k;

        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_an", {28'b0, an}, 32'hF);
        chk("reset_cathode", {24'b0, cathode}, 32'hFF);
        chk("reset_ready", {31'b0, load_ready}, 32'h1);
        rst_n = 1'b1;

        // Free-running scan with blank shadow
        idle(40, 1'b1);

        // Single load, displayed after the next frame boundary
        load_word(32'hFF11_0385);
        idle(3 * FRAME_LEN, 1'b1);

        // Back-to-back loads: second one stalls until promotion
        load_word(32'h1234_5678);
        load_word(32'h9ABC_DEF0);
        idle(3 * FRAME_LEN, 1'b1);

        // Drop enable mid-SHOW of digit 2 for 10 cycles
        k = 0;
        while (m_pos != 2 * RD + 1 && k < 2 * FRAME_LEN) begin
            step(1'b1, 1'b0, 32'h0, acc);
            k++;
        end
        idle(10, 1'b0);
        idle(2 * FRAME_LEN, 1'b1);

        // Reset with a loaded shadow, then stay blank until a new load
        reset_mid_frame();
        idle(3 * FRAME_LEN, 1'b1);
        load_word(32'h0102_0408);
        idle(2 * FRAME_LEN, 1'b1);

        // Randomized traffic with enable gaps and producer hold
        hv = 1'b0;
        hw = '0;
        for (int i = 0; i < 3000; i++) begin
            if (hv) begin
                v = 1'b1;
                w = hw;
            end else begin
                v = ($urandom_range(0, 5) == 0);
                w = $urandom;
            end
            e = ($urandom_range(0, 9) != 0);
            step(e, v, w, acc);
            hv = v && !acc;
            hw = w;
            if (i == 1500) begin
                reset_mid_frame();
                hv = 1'b0;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
